fetch_if_id_stage: RTL
======================

Name: fetch_if_id_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline latch for the 5-stage LC-3b pipeline. It drives the split instruction memory port, keeps the PC, and presents IF_ID_ir/IF_ID_pc/IF_ID_valid to decode and to the hazard bubbler. It consumes the bubbler's gen_bubble (hold) and squash_ID (flush IF/ID), plus redirect from EX/MEM. A one-entry skid buffer ensures a memory response arriving during a stall is never lost.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_WORD, 16'h0000, encoding inserted on flush (BR with nzp=000, never taken).

Ports:
clk  in  1  pipeline clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
imem_address  out  16  instruction fetch address.
imem_read  out  1  fetch request; held until imem_resp.
imem_resp  in  1  single-cycle read-complete strobe.
imem_rdata  in  16  instruction word, valid when imem_resp=1.
gen_bubble  in  1  from bubbler: hold PC and IF/ID this cycle.
squash_ID  in  1  from bubbler: replace IF/ID contents with NOP.
mem_stall  in  1  downstream stall (data memory busy); same effect as gen_bubble.
pc_load  in  1  redirect (taken branch/JMP/JSR/TRAP resolved).
pc_target  in  16  redirect address.
IF_ID_ir  out  16  latched instruction.
IF_ID_pc  out  16  latched instruction address + 2.
IF_ID_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: pc=RESET_PC, req_addr=RESET_PC, IF_ID_ir=NOP_WORD, IF_ID_pc=16'h0000, IF_ID_valid=0, state=S_FETCH, discard=0, skid empty, imem_read=0 during the reset cycle.
- stall = gen_bubble | mem_stall. Per-cycle priority: reset > pc_load > squash_ID > stall > advance.
- States: S_FETCH (imem_read=1) and S_HELD (imem_read=0, skid holds a fetched word).
- Address: imem_address=req_addr. req_addr <= pc on the cycle a new request starts. It stays stable from the first imem_read cycle through the resp cycle inclusive, even if pc changes.
- S_FETCH, imem_resp=1, discard=0, no pc_load:
  - If !stall and !squash: IF_ID <= {rdata, req_addr+2, valid=1}, pc <= req_addr+2, new request next cycle.
  - If stall or squash: skid <= {rdata, req_addr+2}, pc <= req_addr+2, go to S_HELD.
- S_FETCH, no resp: if !stall, IF_ID <= {NOP_WORD, valid=0}; if stall, IF_ID holds.
- S_HELD: when !stall and !squash, IF_ID <= skid with valid=1, then return to S_FETCH. Otherwise hold.
- squash_ID: IF_ID <= {NOP_WORD, IF_ID_pc unchanged, valid=0}. PC and the outstanding request are unaffected.
- pc_load:
  - pc <= pc_target, IF_ID <= NOP valid=0, skid cleared, state=S_FETCH.
  - If a request is outstanding and imem_resp=0 this cycle, set discard=1.
  - If imem_resp=1 in the same cycle, the data is dropped and discard stays 0.
- discard=1: keep imem_read=1 at the old req_addr until resp, drop the data, clear discard, then fetch from pc. A second pc_load while discard=1 updates pc only.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000. No alignment check; bit 0 passes through.
- gen_bubble and squash_ID together: squash wins for the IF/ID contents; PC still holds.

Decomposition:
- lc3b_types: add lc3b_fetch_state enum {S_FETCH, S_HELD} and a named constant for NOP_WORD. Reuse lc3b_word for 16-bit buses.
- One sub-module: if_id_latch. It holds the ir/pc/valid register with load, hold and flush controls. The skid buffer reuses the existing parameterised register.

Test Plan:
- Reset then sequential fetch, 1-cycle memory latency: imem_address 0x0000, 0x0002, 0x0004 on successive requests. IF_ID_ir equals rdata, IF_ID_pc = addr+2, valid=1.
- Resp at addr 0x0004 while gen_bubble=1 for 2 cycles -> S_HELD, imem_read=0, IF_ID unchanged. On release, IF_ID_ir = word@0x0004, IF_ID_pc=0x0006, next request at 0x0006.
- pc_load=1, pc_target=0x3000, while the request to 0x0010 is outstanding (resp 3 cycles later) -> imem_address stays 0x0010 until resp. That word never reaches IF_ID. The next request is at 0x3000 and IF_ID_valid=0 throughout.
- squash_ID pulse with IF_ID holding 0x1234 -> next cycle IF_ID_ir=0x0000, valid=0. The PC sequence is unaffected.
- pc_load and imem_resp in the same cycle (target 0x0100) -> rdata dropped, next imem_address=0x0100, discard never set.
- reset asserted mid-request, and separately pc_target=0xFFFE sequential -> after reset imem_address=RESET_PC and valid=0. The fetch after 0xFFFE is at 0x0000.

Source files
------------

// File: rtl/fetch_if_id_stage_pkg.sv
// Shared LC-3b types for the fetch stage: word type, fetch FSM states, NOP encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HELD  = 1'b1
  } lc3b_fetch_state;

  // BR with nzp=000: never taken, so it is a safe bubble encoding.
  localparam lc3b_word LC3B_NOP_WORD = 16'h0000;

endpackage

// File: rtl/fetch_if_id_stage_if_id_latch.sv
// IF/ID pipeline register: ir/pc/valid with load, hold and flush (flush wins over load).
import lc3b_types::*;

module if_id_latch #(
  parameter lc3b_word NOP_WORD = LC3B_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] ir_in,
  input  logic [15:0] pc_in,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      // A bubble keeps the old pc so downstream debug still sees the last address.
      ir    <= NOP_WORD;
      valid <= 1'b0;
    end else if (load) begin
      ir    <= ir_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_if_id_stage.sv
// LC-3b instruction fetch stage with IF/ID latch, one-entry skid buffer and redirect discard.
import lc3b_types::*;

module fetch_if_id_stage #(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word NOP_WORD = LC3B_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        gen_bubble,
  input  logic        squash_ID,
  input  logic        mem_stall,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic [15:0] IF_ID_ir,
  output logic [15:0] IF_ID_pc,
  output logic        IF_ID_valid
);

  lc3b_fetch_state state, state_next;
  lc3b_word        pc, pc_next;
  lc3b_word        req_addr, req_next;
  logic            discard, discard_next;
  lc3b_word        skid_ir, skid_pc;
  logic            skid_load, skid_clear;
  logic            lat_load, lat_flush;
  lc3b_word        lat_ir, lat_pc;
  logic            stall;
  lc3b_word        seq_pc;

  assign stall        = gen_bubble | mem_stall;
  assign seq_pc       = req_addr + 16'd2;
  assign imem_address = req_addr;
  assign imem_read    = (state == S_FETCH) && !reset;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    req_next     = req_addr;
    discard_next = discard;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    lat_load     = 1'b0;
    lat_flush    = 1'b0;
    lat_ir       = imem_rdata;
    lat_pc       = seq_pc;

    if (pc_load) begin
      pc_next    = pc_target;
      state_next = S_FETCH;
      skid_clear = 1'b1;
      lat_flush  = 1'b1;
      // An unanswered request cannot be cancelled on the bus, so its reply must be dropped later.
      if (state == S_FETCH && !imem_resp) begin
        discard_next = 1'b1;
      end else begin
        discard_next = 1'b0;
        req_next     = pc_target;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_resp && !discard) begin
            pc_next  = seq_pc;
            req_next = seq_pc;
            if (stall || squash_ID) begin
              skid_load  = 1'b1;
              state_next = S_HELD;
              lat_flush  = squash_ID;
            end else begin
              lat_load = 1'b1;
            end
          end else begin
            if (imem_resp) begin
              discard_next = 1'b0;
              req_next     = pc;
            end
            lat_flush = squash_ID || !stall;
          end
        end
        S_HELD: begin
          req_next = pc;
          if (squash_ID) begin
            lat_flush = 1'b1;
          end else if (!stall) begin
            lat_load   = 1'b1;
            lat_ir     = skid_ir;
            lat_pc     = skid_pc;
            state_next = S_FETCH;
          end
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_next;
      discard  <= discard_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || skid_clear) begin
      skid_ir <= '0;
      skid_pc <= '0;
    end else if (skid_load) begin
      skid_ir <= imem_rdata;
      skid_pc <= seq_pc;
    end
  end

  if_id_latch #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (lat_load),
    .flush (lat_flush),
    .ir_in (lat_ir),
    .pc_in (lat_pc),
    .ir    (IF_ID_ir),
    .pc    (IF_ID_pc),
    .valid (IF_ID_valid)
  );

endmodule
